// File: rtl/cp0_unit.sv
// CP0 coprocessor: SR/Cause/EPC/PRId registers, exception and interrupt request
// generation, mtc0/mfc0 access and eret handling for the MEM stage.
module cp0_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        en,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        req,
    output logic [31:0] EPCOut,
    output logic [31:0] DOut
);

    localparam logic [4:0]  REG_SR    = 5'd12;
    localparam logic [4:0]  REG_CAUSE = 5'd13;
    localparam logic [4:0]  REG_EPC   = 5'd14;
    localparam logic [4:0]  REG_PRID  = 5'd15;
    localparam logic [31:0] PRID_VAL  = 32'h2024_1106;

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic        w_req;
    logic        w_wr_sr;
    logic        w_wr_epc;
    logic [31:0] w_sr;
    logic [31:0] w_cause;

    // A victim in a delay slot restarts at its branch, one word earlier.
    function automatic logic [31:0] victim_epc(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

    assign w_int_req = (|(HWInt & r_im)) & r_ie & ~r_exl;
    assign w_exc_req = (ExcCodeIn != 5'd0) & ~r_exl;
    assign w_req     = w_int_req | w_exc_req;
    assign w_wr_sr   = en & (A2 == REG_SR);
    assign w_wr_epc  = en & (A2 == REG_EPC);

    assign w_sr    = {16'd0, r_im, 8'd0, r_exl, r_ie};
    assign w_cause = {r_bd, 15'd0, r_ip, 3'd0, r_exccode, 2'd0};

    assign req    = w_req;
    assign EPCOut = r_epc;

    always_comb begin
        DOut = 32'd0;
        case (A1)
            REG_SR:    DOut = w_sr;
            REG_CAUSE: DOut = w_cause;
            REG_EPC:   DOut = r_epc;
            REG_PRID:  DOut = PRID_VAL;
            default:   DOut = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_im      <= 6'd0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_bd      <= 1'b0;
            r_ip      <= 6'd0;
            r_exccode <= 5'd0;
            r_epc     <= 32'd0;
        end else begin
            r_ip <= HWInt;
            if (w_req) begin
                // Exception entry overrides any mtc0 or eret in the same cycle.
                r_exl     <= 1'b1;
                r_bd      <= BDIn;
                r_exccode <= w_int_req ? 5'd0 : ExcCodeIn;
                r_epc     <= victim_epc(VPC, BDIn);
            end else begin
                if (w_wr_sr) begin
                    r_im  <= DIn[15:10];
                    r_ie  <= DIn[0];
                    r_exl <= DIn[1] & ~EXLClr;
                end else if (EXLClr) begin
                    r_exl <= 1'b0;
                end
                if (w_wr_epc) begin
                    r_epc <= DIn;
                end
            end
        end
    end

endmodule
